boot_loader: RTL and testbench

- Parametrised power-on program loader placed between the image source ROM, the single-port program BSRAM (Gowin_SP) and the CPU.
- Copies an IMG_DEPTH-word image into BSRAM and optionally reads it back to verify it.
- Holds the CPU in reset until the load is good, then hands the BSRAM address bus to the CPU program counter.
- A software or button `start` pulse re-runs the load without a global reset.

---
 rtl/boot_pkg.sv | 22 ++
 rtl/boot_align_dly.sv | 47 ++++
 rtl/boot_loader.sv | 167 ++++++++++++++++
 tb/tb_boot_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and sizing helpers for the program loader.
`default_nettype none

package boot_pkg;

    typedef enum logic [1:0] {
        WR  = 2'd0,
        VR  = 2'd1,
        RUN = 2'd2,
        ERR = 2'd3
    } boot_state_e;

    // The image source presents its word one clock after the address.
    localparam int IMG_SRC_LAT = 1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/boot_align_dly.sv
// boot_align_dly: DEPTH-stage data delay line with a valid bit; DEPTH=0 is a wire.
`default_nettype none

module boot_align_dly #(
    parameter int W     = 16,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign valid_o        = valid_i;
        assign data_o         = data_i;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld_q;
        logic [W-1:0]     dat_q [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    dat_q[i] <= '0;
                end
            end else begin
                vld_q[0] <= valid_i;
                dat_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign valid_o = vld_q[DEPTH-1];
        assign data_o  = dat_q[DEPTH-1];
    end

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// boot_loader: copies an image ROM into program BSRAM, optionally verifies it,
// then releases the CPU and hands the BSRAM address bus to its program counter.
`default_nettype none

module boot_loader
    import boot_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 11,
    parameter int IMG_DEPTH = 16,
    parameter int VERIFY    = 1,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    // The verify pass runs the index past the image end while compares drain.
    localparam int                IDX_W        = cnt_w(IMG_DEPTH + RD_LAT - 1);
    localparam int                CMP_LAT      = IMG_SRC_LAT + RD_LAT - 1;
    localparam logic [IDX_W-1:0]  IDX_END      = IDX_W'(IMG_DEPTH);
    localparam logic [IDX_W-1:0]  IDX_LAST_CMP = IDX_W'(IMG_DEPTH - 1);
    localparam logic [IDX_W-1:0]  IDX_CMP_LAT  = IDX_W'(CMP_LAT);
    localparam logic [IDX_W-1:0]  IDX_ONE      = IDX_W'(1);

    boot_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              cpu_rst_n_q;
    logic              src_valid_q;

    logic              dly_valid;
    logic [DATA_W-1:0] dly_data;
    logic              wr_active;
    logic              rd_issue;
    logic              cmp_en;
    logic              cmp_fail;
    logic [IDX_W-1:0]  cmp_idx;

    assign wr_active = (state_q == WR) && (idx_q != '0);
    assign rd_issue  = (state_q == VR) && (idx_q < IDX_END);
    assign cmp_idx   = idx_q - IDX_CMP_LAT;
    assign cmp_en    = (state_q == VR) && dly_valid;
    assign cmp_fail  = cmp_en && (mem_dout != dly_data);

    // Source words trail their read address by one clock; stretch them to BSRAM latency.
    boot_align_dly #(
        .W     (DATA_W),
        .DEPTH (RD_LAT - 1)
    ) u_align (
        .clk     (clk),
        .rst_n   (rst),
        .valid_i (src_valid_q),
        .data_i  (img_data),
        .valid_o (dly_valid),
        .data_o  (dly_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WR;
            idx_q       <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            cpu_rst_n_q <= 1'b0;
            src_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            cpu_rst_n_q <= (state_d == RUN);
            src_valid_q <= rd_issue;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        case (state_q)
            WR: begin
                if (idx_q == IDX_END) begin
                    idx_d   = '0;
                    state_d = (VERIFY != 0) ? VR : RUN;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            VR: begin
                if (cmp_fail) begin
                    state_d    = ERR;
                    idx_d      = '0;
                    err_d      = 1'b1;
                    err_addr_d = ADDR_W'(cmp_idx);
                end else if (cmp_en && (cmp_idx == IDX_LAST_CMP)) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            RUN, ERR: begin
                if (start) begin
                    state_d    = WR;
                    idx_d      = '0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end
            end
            default: state_d = WR;
        endcase
    end

    always_comb begin
        img_addr = '0;
        mem_wre  = 1'b0;
        mem_ad   = '0;
        mem_din  = '0;
        case (state_q)
            WR: begin
                if (idx_q < IDX_END) begin
                    img_addr = ADDR_W'(idx_q);
                end
                if (wr_active) begin
                    mem_wre = 1'b1;
                    mem_ad  = ADDR_W'(idx_q - IDX_ONE);
                    mem_din = img_data;
                end
            end
            VR: begin
                if (rd_issue) begin
                    img_addr = ADDR_W'(idx_q);
                    mem_ad   = ADDR_W'(idx_q);
                end
            end
            RUN:     mem_ad = cpu_pc;
            default: mem_ad = '0;
        endcase
    end

    assign mem_ce    = 1'b1;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = (state_q == WR) || (state_q == VR);
    assign done      = (state_q == RUN);
    assign err       = err_q;
    assign err_addr  = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed checks of three loader configurations against ROM/BSRAM models.
`default_nettype none

module tb_boot_loader;

    localparam int DW = 16;
    localparam int AW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_bc, start_a, start_b, start_c, fault_a;
    logic [AW-1:0] cpu_pc_a, pc_zero;

    logic [AW-1:0] img_addr_a, img_addr_b, img_addr_c;
    logic [DW-1:0] img_data_a, img_data_b, img_data_c;
    logic          mem_ce_a, mem_ce_b, mem_ce_c;
    logic          mem_wre_a, mem_wre_b, mem_wre_c;
    logic [AW-1:0] mem_ad_a, mem_ad_b, mem_ad_c;
    logic [DW-1:0] mem_din_a, mem_din_b, mem_din_c;
    logic [DW-1:0] mem_dout_a, mem_dout_b, mem_dout_c, mem_dout_c1;
    logic          cpu_rst_n_a, cpu_rst_n_b, cpu_rst_n_c;
    logic          busy_a, busy_b, busy_c;
    logic          done_a, done_b, done_c;
    logic          err_a, err_b, err_c;
    logic [AW-1:0] err_addr_a, err_addr_b, err_addr_c;

    int total = 0;
    int bad   = 0;

    boot_loader u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .img_addr(img_addr_a), .img_data(img_data_a),
        .cpu_pc(cpu_pc_a), .mem_ce(mem_ce_a), .mem_wre(mem_wre_a), .mem_ad(mem_ad_a),
        .mem_din(mem_din_a), .mem_dout(mem_dout_a), .cpu_rst_n(cpu_rst_n_a), .busy(busy_a),
        .done(done_a), .err(err_a), .err_addr(err_addr_a)
    );

    boot_loader #(.IMG_DEPTH(1), .VERIFY(0)) u_dut_b (
        .clk(clk), .rst(rst_bc), .start(start_b), .img_addr(img_addr_b), .img_data(img_data_b),
        .cpu_pc(pc_zero), .mem_ce(mem_ce_b), .mem_wre(mem_wre_b), .mem_ad(mem_ad_b),
        .mem_din(mem_din_b), .mem_dout(mem_dout_b), .cpu_rst_n(cpu_rst_n_b), .busy(busy_b),
        .done(done_b), .err(err_b), .err_addr(err_addr_b)
    );

    boot_loader #(.RD_LAT(2)) u_dut_c (
        .clk(clk), .rst(rst_bc), .start(start_c), .img_addr(img_addr_c), .img_data(img_data_c),
        .cpu_pc(pc_zero), .mem_ce(mem_ce_c), .mem_wre(mem_wre_c), .mem_ad(mem_ad_c),
        .mem_din(mem_din_c), .mem_dout(mem_dout_c), .cpu_rst_n(cpu_rst_n_c), .busy(busy_c),
        .done(done_c), .err(err_c), .err_addr(err_addr_c)
    );

    // Image ROMs: registered output, one clock after the address.
    always @(posedge clk) img_data_a <= 16'h00A0 + 16'(img_addr_a);
    always @(posedge clk) img_data_b <= 16'h5A50 + 16'(img_addr_b);
    always @(posedge clk) img_data_c <= 16'h00A0 + 16'(img_addr_c);

    logic [DW-1:0] mem_a [0:2047];
    logic [DW-1:0] mem_b [0:2047];
    logic [DW-1:0] mem_c [0:2047];
    int wr_cnt_a = 0;

    always @(posedge clk) begin
        if (mem_ce_a) begin
            if (mem_wre_a) begin
                mem_a[mem_ad_a] <= mem_din_a;
                wr_cnt_a        <= wr_cnt_a + 1;
            end
            mem_dout_a <= (fault_a && mem_ad_a == 11'd5) ? 16'hFFFF : mem_a[mem_ad_a];
        end
    end

    always @(posedge clk) begin
        if (mem_ce_b) begin
            if (mem_wre_b) mem_b[mem_ad_b] <= mem_din_b;
            mem_dout_b <= mem_b[mem_ad_b];
        end
    end

    always @(posedge clk) begin
        if (mem_ce_c) begin
            if (mem_wre_c) mem_c[mem_ad_c] <= mem_din_c;
            mem_dout_c1 <= mem_c[mem_ad_c];
        end
        mem_dout_c <= mem_dout_c1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int n);
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle_a(output int n);
        n = 0;
        while (busy_a !== 1'b0 && n < 200) begin
            step();
            n++;
        end
    endtask

    int n;
    int snap;
    logic exp_wr;

    initial begin
        rst_a = 1'b0; rst_bc = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        fault_a = 1'b0; cpu_pc_a = '0; pc_zero = '0;
        repeat (3) step();

        chk("rst_img_addr", img_addr_a, 0);
        chk("rst_wre", mem_wre_a, 0);
        chk("rst_ce", mem_ce_a, 1);
        chk("rst_din", mem_din_a, 0);
        chk("rst_cpu_rst_n", cpu_rst_n_a, 0);
        chk("rst_busy", busy_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_err_addr", err_addr_a, 0);

        @(negedge clk);
        rst_a = 1'b1; rst_bc = 1'b1;
        #1;
        for (int c = 0; c <= 40; c++) begin
            if (c > 0) step();
            exp_wr = (c >= 1 && c <= 16);
            chk("a_wre", mem_wre_a, exp_wr);
            if (exp_wr) begin
                chk("a_ad", mem_ad_a, c - 1);
                chk("a_din", mem_din_a, 16'h00A0 + c - 1);
            end
            chk("a_done", done_a, c >= 34);
            chk("a_cpu_rst_n", cpu_rst_n_a, c >= 34);
            chk("b_wre", mem_wre_b, c == 1);
            if (c == 1) begin
                chk("b_ad", mem_ad_b, 0);
                chk("b_din", mem_din_b, 16'h5A50);
            end
            chk("b_done", done_b, c >= 2);
            chk("c_done", done_c, c >= 35);
            chk("c_cpu_rst_n", cpu_rst_n_c, c >= 35);
        end
        chk("a_err_after_load", err_a, 0);
        chk("a_busy_after_load", busy_a, 0);
        chk("c_err_after_load", err_c, 0);

        for (int p = 0; p < 3; p++) begin
            cpu_pc_a = AW'(p);
            #1;
            chk("run_mem_ad", mem_ad_a, p);
            chk("run_wre", mem_wre_a, 0);
            step();
        end

        pulse_start_a();
        chk("restart_cpu_rst_n", cpu_rst_n_a, 0);
        chk("restart_busy", busy_a, 1);
        chk("restart_done", done_a, 0);
        wait_done_a(n);
        chk("reload_latency", n, 34);
        chk("reload_err", err_a, 0);

        fault_a = 1'b1;
        pulse_start_a();
        wait_idle_a(n);
        chk("fault_latency", n, 24);
        chk("fault_err", err_a, 1);
        chk("fault_err_addr", err_addr_a, 5);
        chk("fault_done", done_a, 0);
        repeat (3) step();
        chk("fault_cpu_rst_n", cpu_rst_n_a, 0);
        chk("fault_err_hold", err_a, 1);
        chk("fault_mem_ad", mem_ad_a, 0);
        chk("fault_wre", mem_wre_a, 0);

        fault_a = 1'b0;
        pulse_start_a();
        chk("clear_err", err_a, 0);
        chk("clear_err_addr", err_addr_a, 0);
        chk("clear_busy", busy_a, 1);
        wait_done_a(n);
        chk("recover_latency", n, 34);
        chk("recover_done", done_a, 1);
        chk("recover_err", err_a, 0);

        pulse_start_a();
        repeat (7) step();
        chk("mid_wre", mem_wre_a, 1);
        chk("mid_ad", mem_ad_a, 6);
        #2;
        rst_a = 1'b0;
        #1;
        snap = wr_cnt_a;
        chk("mid_rst_wre", mem_wre_a, 0);
        chk("mid_rst_cpu_rst_n", cpu_rst_n_a, 0);
        chk("mid_rst_busy", busy_a, 1);
        chk("mid_rst_img_addr", img_addr_a, 0);
        chk("mid_rst_din", mem_din_a, 0);
        repeat (3) begin
            step();
            chk("mid_rst_hold_wre", mem_wre_a, 0);
        end
        chk("mid_rst_no_write", wr_cnt_a, snap);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("rerun_img_addr", img_addr_a, 0);
        step();
        chk("rerun_wre", mem_wre_a, 1);
        chk("rerun_ad", mem_ad_a, 0);
        chk("rerun_din", mem_din_a, 16'h00A0);
        wait_done_a(n);
        chk("rerun_latency", n, 33);
        chk("rerun_err", err_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
